trap_sequencer: RTL and testbench

// - Consumes the 4-bit priority-encoded trap reason from the trap priority encoder and runs the trap entry sequence.
// - Sequence: latch reason, flush pipeline, save PC/PSR, then issue the vector fetch.
// - Sits between the trap encoder and the fetch/PSR control logic.
// - Reports fatal conditions (double trap, flush timeout) via halt.

---
 rtl/trap_pkg.sv | 20 ++
 rtl/trap_sequencer.sv | 138 +++++++++++++
 tb/tb_trap_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_pkg.sv
// Shared types and helpers for the trap entry sequencer.
package trap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    SAVE,
    VECTOR,
    ERROR
  } state_t;

  localparam logic [3:0] REASON_NONE  = 4'h0;
  localparam logic [3:0] REASON_IOINT = 4'h1;

  // Only the external I/O interrupt can be held off by PSR.ET.
  function automatic logic is_maskable(input logic [3:0] reason);
    return reason == REASON_IOINT;
  endfunction

endpackage

// File: rtl/trap_sequencer.sv
// Trap entry sequencer: latch reason, flush pipe, save PC/PSR, issue vector fetch.
// Optional trap statistics counter enabled by defining TRAP_STATS_EN.
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int FLUSH_TMO = 64
`ifdef TRAP_STATS_EN
  , parameter int CNT_W   = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        trap_reason,
  input  logic              traps_en,
  input  logic [ADDR_W-1:0] cur_pc,
  input  logic [7:0]        cur_psr,
  input  logic [ADDR_W-1:0] tbr_base,
  input  logic              pipe_drained,
  output logic              flush,
  output logic              save_we,
  output logic [ADDR_W-1:0] save_pc,
  output logic [7:0]        save_psr,
  output logic              vec_valid,
  input  logic              vec_ready,
  output logic [ADDR_W-1:0] vec_addr,
  output logic              busy,
  output logic              halt
`ifdef TRAP_STATS_EN
  , output logic [CNT_W-1:0] trap_cnt
`endif
);

  localparam int TMO_W = (FLUSH_TMO > 1) ? $clog2(FLUSH_TMO) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FLUSH_TMO - 1);

  state_t           state, state_nxt;
  logic [3:0]       reason_q;
  logic [TMO_W-1:0] tmo_cnt;
  logic             trap_pending;
  logic             accept;
  logic             double_trap;
  logic             unused_tbr_low;

  assign unused_tbr_low = ^tbr_base[7:0];

  assign trap_pending = (state == IDLE) && (trap_reason != REASON_NONE);
  // With traps disabled, an IOINT is simply held off; anything else is fatal.
  assign accept       = trap_pending && traps_en;
  assign double_trap  = trap_pending && !traps_en && !is_maskable(trap_reason);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reason_q <= REASON_NONE;
      save_pc  <= '0;
      save_psr <= '0;
      vec_addr <= '0;
      tmo_cnt  <= '0;
    end else begin
      if (accept) begin
        reason_q <= trap_reason;
        save_pc  <= cur_pc;
        save_psr <= cur_psr;
      end
      if (state == FLUSH) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end else begin
        tmo_cnt <= '0;
      end
      // Registered so the address cannot move while vec_valid waits for ready.
      if (state == SAVE) begin
        vec_addr <= {tbr_base[ADDR_W-1:8], reason_q, 4'h0};
      end
    end
  end

`ifdef TRAP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      trap_cnt <= '0;
    end else if (accept) begin
      trap_cnt <= trap_cnt + CNT_W'(1);
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    flush     = 1'b0;
    save_we   = 1'b0;
    vec_valid = 1'b0;
    halt      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = FLUSH;
        end else if (double_trap) begin
          state_nxt = ERROR;
        end
      end
      FLUSH: begin
        flush = 1'b1;
        if (pipe_drained) begin
          state_nxt = SAVE;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = ERROR;
        end
      end
      SAVE: begin
        save_we   = 1'b1;
        state_nxt = VECTOR;
      end
      VECTOR: begin
        vec_valid = 1'b1;
        if (vec_ready) begin
          state_nxt = IDLE;
        end
      end
      ERROR: begin
        halt = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed scoreboard bench for trap_sequencer (trap_cnt checks when TRAP_STATS_EN is defined).
module tb_trap_sequencer;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] pc;
    logic [7:0]  psr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  trap_reason;
  logic        traps_en;
  logic [31:0] cur_pc;
  logic [7:0]  cur_psr;
  logic [31:0] tbr_base;
  logic        pipe_drained;
  logic        flush;
  logic        save_we;
  logic [31:0] save_pc;
  logic [7:0]  save_psr;
  logic        vec_valid;
  logic        vec_ready;
  logic [31:0] vec_addr;
  logic        busy;
  logic        halt;
`ifdef TRAP_STATS_EN
  logic [15:0] trap_cnt;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  trap_sequencer dut (
    .clk(clk), .rst(rst), .trap_reason(trap_reason), .traps_en(traps_en),
    .cur_pc(cur_pc), .cur_psr(cur_psr), .tbr_base(tbr_base),
    .pipe_drained(pipe_drained), .flush(flush), .save_we(save_we),
    .save_pc(save_pc), .save_psr(save_psr), .vec_valid(vec_valid),
    .vec_ready(vec_ready), .vec_addr(vec_addr), .busy(busy), .halt(halt)
`ifdef TRAP_STATS_EN
    , .trap_cnt(trap_cnt)
`endif
  );

  task automatic chk(input string tag, input bit ok);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full trap: flush lasts drain_cyc cycles, ready arrives after rdy_dly waiting cycles.
  task automatic trap_seq(input logic [3:0] reason, input logic [31:0] pc,
                          input logic [7:0] psr, input int drain_cyc, input int rdy_dly);
    exp_t e;
    e.addr = {tbr_base[31:8], reason, 4'h0};
    e.pc   = pc;
    e.psr  = psr;
    exp_q.push_back(e);
    trap_reason = reason;
    traps_en    = 1'b1;
    cur_pc      = pc;
    cur_psr     = psr;
    step();
    cur_pc  = ~pc;
    cur_psr = ~psr;
    for (int i = 0; i < drain_cyc; i++) begin
      chk("flush_active", flush === 1'b1);
      chk("busy_in_flush", busy === 1'b1);
      trap_reason  = 4'($urandom);
      pipe_drained = (i == drain_cyc - 1);
      step();
    end
    pipe_drained = 1'b0;
    trap_reason  = 4'h0;
    chk("flush_done", flush === 1'b0);
    chk("save_we", save_we === 1'b1);
    chk("save_pc", save_pc === exp_q[0].pc);
    chk("save_psr", save_psr === exp_q[0].psr);
    step();
    chk("save_we_one_cycle", save_we === 1'b0);
    for (int i = 0; i <= rdy_dly; i++) begin
      chk("vec_valid", vec_valid === 1'b1);
      chk("vec_addr", vec_addr === exp_q[0].addr);
      trap_reason = 4'($urandom);
      vec_ready   = (i == rdy_dly);
      step();
    end
    e = exp_q.pop_front();
    vec_ready   = 1'b0;
    trap_reason = 4'h0;
    chk("vec_valid_drop", vec_valid === 1'b0);
    chk("busy_after_hs", busy === 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] a;
    rst          = 1'b1;
    trap_reason  = 4'h0;
    traps_en     = 1'b0;
    cur_pc       = 32'h0;
    cur_psr      = 8'h0;
    tbr_base     = 32'hA5C3_E7FF;
    pipe_drained = 1'b0;
    vec_ready    = 1'b0;
    step();
    step();
    rst = 1'b0;

    chk("rst_flush", flush === 1'b0);
    chk("rst_save_we", save_we === 1'b0);
    chk("rst_vec_valid", vec_valid === 1'b0);
    chk("rst_busy", busy === 1'b0);
    chk("rst_halt", halt === 1'b0);
    chk("rst_save_pc", save_pc === 32'h0);
    chk("rst_save_psr", save_psr === 8'h0);
    chk("rst_vec_addr", vec_addr === 32'h0);
`ifdef TRAP_STATS_EN
    chk("rst_trap_cnt", trap_cnt === 16'h0);
`endif

    // Reason 5, drained on second flush cycle, ready immediately.
    trap_seq(4'h5, 32'h1000_0040, 8'hC3, 2, 0);
    chk("vec_low_byte_5", exp_q.size() == 0);

    // Masked IOINT.
    trap_reason = 4'h1;
    traps_en    = 1'b0;
    step();
    chk("ioint_masked_busy", busy === 1'b0);
    step();
    chk("ioint_masked_busy2", busy === 1'b0);
    chk("ioint_masked_halt", halt === 1'b0);

    // Unmasked IOINT, ready held low 5 cycles, different base.
    tbr_base = 32'h1234_5600;
    trap_seq(4'h1, 32'hDEAD_BEE0, 8'h81, 1, 5);
    n = 0;
    a = vec_addr;
    chk("ioint_vec_low", a[7:0] === 8'h10);
    chk("ioint_vec_high", a[31:8] === 24'h123456);

    // Back-to-back sequence with longer drain.
    trap_seq(4'hF, 32'h0000_0FFC, 8'h00, 7, 2);

    // Double trap.
    trap_reason = 4'h3;
    traps_en    = 1'b0;
    step();
    trap_reason = 4'h0;
    chk("dbl_halt", halt === 1'b1);
    chk("dbl_busy", busy === 1'b1);
    chk("dbl_flush", flush === 1'b0);
    traps_en = 1'b1;
    trap_reason = 4'h7;
    pipe_drained = 1'b1;
    vec_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("dbl_sticky", halt === 1'b1);
    chk("dbl_no_vec", vec_valid === 1'b0);
    chk("dbl_no_save", save_we === 1'b0);
    trap_reason  = 4'h0;
    pipe_drained = 1'b0;
    vec_ready    = 1'b0;
    do_reset();
    chk("dbl_cleared", halt === 1'b0);
    chk("dbl_cleared_busy", busy === 1'b0);

    // Flush timeout.
    trap_reason = 4'h2;
    traps_en    = 1'b1;
    step();
    trap_reason = 4'h0;
    n = 0;
    while (flush && n < 200) begin
      n++;
      step();
    end
    chk("tmo_flush_cycles", n == 64);
    chk("tmo_halt", halt === 1'b1);
    step();
    step();
    chk("tmo_halt_sticky", halt === 1'b1);
    chk("tmo_no_flush", flush === 1'b0);
    do_reset();
    chk("tmo_cleared", halt === 1'b0);

    // Reset while in SAVE.
    trap_reason  = 4'h9;
    cur_pc       = 32'h5555_0000;
    cur_psr      = 8'h5A;
    step();
    trap_reason  = 4'h0;
    pipe_drained = 1'b1;
    step();
    pipe_drained = 1'b0;
    chk("abort_in_save", save_we === 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", busy === 1'b0);
    chk("abort_save_we", save_we === 1'b0);
    chk("abort_vec_valid", vec_valid === 1'b0);
    chk("abort_save_pc", save_pc === 32'h0);
    chk("abort_vec_addr", vec_addr === 32'h0);
    step();
    chk("abort_no_vec_after", vec_valid === 1'b0);
    chk("abort_idle_after", busy === 1'b0);

`ifdef TRAP_STATS_EN
    chk("cnt_after_rst", trap_cnt === 16'h0);
    trap_seq(4'h4, 32'h0000_0100, 8'h11, 1, 0);
    trap_seq(4'h1, 32'h0000_0200, 8'h22, 2, 1);
    trap_seq(4'hA, 32'h0000_0300, 8'h33, 3, 0);
    chk("cnt_three", trap_cnt === 16'h3);
`endif

    chk("scoreboard_empty", exp_q.size() == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
